grid_map_writer: RTL
====================

# grid_map_writer

Downstream consumer of the coordinate-entry stage: accepts (x, y) obstacle coordinates over a valid/ready handshake and records them in an on-chip occupancy bitmap. The bitmap is read by the pathfinding core. The block clears the map after reset, rejects duplicate and out-of-range points, enforces a point limit, and locks the map when the entry stage signals completion.

## Interface
- GRID_W, 16, grid columns; legal x is 0..GRID_W-1
- GRID_H, 16, grid rows; legal y is 0..GRID_H-1
- COORD_W, 5, coordinate width; must satisfy 2^COORD_W ≥ max(GRID_W, GRID_H)
- MAX_POINTS, 32, maximum stored obstacles
- CNT_W, 6, point_count width; must satisfy 2^CNT_W > MAX_POINTS

Ports:
- clk  in  1  clock
- reset  in  1  reset, asynchronous, active-high
- coord_valid  in  1  coordinate present
- coord_x  in  COORD_W  column
- coord_y  in  COORD_W  row
- coord_ready  out  1  block accepts a coordinate this cycle
- finish  in  1  single-cycle pulse: entry complete
- rd_en  in  1  read request
- rd_x  in  COORD_W  read column
- rd_y  in  COORD_W  read row
- rd_occupied  out  1  registered read data
- point_count  out  CNT_W  distinct points stored
- dup_flag  out  1  one-cycle pulse: duplicate rejected
- oob_flag  out  1  one-cycle pulse: out-of-range rejected
- overflow  out  1  sticky: a point was rejected because the map was full
- map_ready  out  1  map locked and valid for pathfinding

## Operation
- Storage: GRID_H rows × GRID_W bits, held in registers.
- States:
  - CLEAR: zeroes one row per cycle, rows 0..GRID_H-1. After row GRID_H-1 is cleared, go to ACCEPT.
  - ACCEPT: coord_ready=1. When coord_valid is high, capture x and y, then go to WRITE. When finish is high with no valid coordinate, go to LOCKED.
  - WRITE: coord_ready=0. Evaluate the captured point in this priority order:
    1. Out of range (x≥GRID_W or y≥GRID_H): pulse oob_flag.
    2. Bit already set: pulse dup_flag.
    3. point_count==MAX_POINTS: set overflow.
    4. Otherwise: set the bit and increment point_count.
    
    Then go to LOCKED if finish_pending is set, else ACCEPT.
  - LOCKED: coord_ready=0, map_ready=1. coord_valid and finish are ignored. The state is left only via reset.
- finish_pending: set when finish arrives in ACCEPT together with coord_valid, or while in WRITE. The captured coordinate is still processed. finish in CLEAR is latched into finish_pending and honored on the first ACCEPT cycle as a transition to LOCKED.
- A rejected point never modifies the bitmap or point_count.
- Reads are legal in every state. While rd_en is high, rd_occupied takes the bit at (rd_x, rd_y) on the next edge; an out-of-range read returns 0. While rd_en is low, rd_occupied holds its value. A read during CLEAR may return stale-or-zero data; consumers must wait for map_ready.
- Reset mid-operation: state goes to CLEAR and every register goes to its reset value. The full clear sweep restarts.

## Timing
- Reset values: coord_ready=0, rd_occupied=0, point_count=0, dup_flag=0, oob_flag=0, overflow=0, map_ready=0. State=CLEAR, finish_pending=0. Bitmap contents are undefined until the sweep completes.
- Clear latency: GRID_H rising edges after reset release; coord_ready rises after edge GRID_H (16 by default).
- coord_ready is a pure decode of state (registered) with no combinational path from inputs.
- Throughput is one coordinate per 2 cycles: the ACCEPT edge captures, the WRITE edge commits.
- dup_flag and oob_flag are high for exactly the one cycle following the WRITE edge.
- point_count and overflow update on the WRITE edge.
- map_ready rises on the edge entering LOCKED: 1 cycle after a lone finish in ACCEPT, or 1 cycle after the WRITE edge when finish_pending is set.
- Read latency is 1 cycle, and a read in the cycle after a WRITE edge sees the new bit.

## Test plan
- Reset, then count edges: coord_ready=0 for the first 16 edges and =1 after edge 16. All flags=0 and point_count=0.
- Write (3,4), then (15,15), then finish: point_count=2 and map_ready=1. Reads return 1 at (3,4) and (15,15), and 0 at (0,0) and (4,3).
- Write (3,4) twice: the second write gives a dup_flag pulse of exactly 1 cycle and point_count stays 1. Write (16,2): oob_flag pulses, point_count is unchanged, and a read of (16,2) returns 0.
- Write 33 distinct points: point_count=32, overflow=1 (sticky), and the 33rd point reads back 0.
- Assert finish together with coord_valid for (7,7): (7,7) is stored, then map_ready=1. A later coord_valid is ignored while coord_ready stays 0.
- Assert reset after 5 points mid-entry: all outputs return to reset values, the 16-cycle clear repeats, and all earlier points read back 0.

Source files
------------

// File: rtl/grid_map_writer.sv
// Occupancy-bitmap writer: clears the map after reset, then records (x, y) obstacle
// points with duplicate/out-of-range/full rejection until the entry stage signals finish.
module grid_map_writer #(
  parameter int GRID_W     = 16,
  parameter int GRID_H     = 16,
  parameter int COORD_W    = 5,
  parameter int MAX_POINTS = 32,
  parameter int CNT_W      = 6
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               coord_valid,
  input  logic [COORD_W-1:0] coord_x,
  input  logic [COORD_W-1:0] coord_y,
  output logic               coord_ready,
  input  logic               finish,
  input  logic               rd_en,
  input  logic [COORD_W-1:0] rd_x,
  input  logic [COORD_W-1:0] rd_y,
  output logic               rd_occupied,
  output logic [CNT_W-1:0]   point_count,
  output logic               dup_flag,
  output logic               oob_flag,
  output logic               overflow,
  output logic               map_ready
);

  localparam int XW = (GRID_W > 1) ? $clog2(GRID_W) : 1;
  localparam int YW = (GRID_H > 1) ? $clog2(GRID_H) : 1;

  typedef enum logic [1:0] {CLEAR, ACCEPT, WRITE, LOCKED} state_t;

  state_t             state, state_nxt;
  logic [YW-1:0]      clr_row;
  logic [COORD_W-1:0] cap_x, cap_y;
  logic [GRID_W-1:0]  bitmap [GRID_H];
  logic               finish_pending;

  logic cap_in_range, cap_is_set, map_full, do_commit, rd_in_range;

  assign cap_in_range = (int'(cap_x) < GRID_W) && (int'(cap_y) < GRID_H);
  assign cap_is_set   = cap_in_range && bitmap[cap_y[YW-1:0]][cap_x[XW-1:0]];
  assign map_full     = (point_count == CNT_W'(MAX_POINTS));
  assign do_commit    = (state == WRITE) && cap_in_range && !cap_is_set && !map_full;
  assign rd_in_range  = (int'(rd_x) < GRID_W) && (int'(rd_y) < GRID_H);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= CLEAR;
    else       state <= state_nxt;
  end

  // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
  always_comb begin
    state_nxt = state;
    unique case (state)
      CLEAR:  if (clr_row == YW'(GRID_H - 1)) state_nxt = ACCEPT;
      ACCEPT: begin
        if (coord_valid)                  state_nxt = WRITE;
        else if (finish || finish_pending) state_nxt = LOCKED;
      end
      WRITE:  state_nxt = (finish_pending || finish) ? LOCKED : ACCEPT;
      LOCKED: state_nxt = LOCKED;
      default: state_nxt = CLEAR;
    endcase
  end

  always_comb begin
    coord_ready = (state == ACCEPT);
    map_ready   = (state == LOCKED);
  end

  // NOTE: registered state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      clr_row        <= '0;
      cap_x          <= '0;
      cap_y          <= '0;
      finish_pending <= 1'b0;
      point_count    <= '0;
      dup_flag       <= 1'b0;
      oob_flag       <= 1'b0;
      overflow       <= 1'b0;
      rd_occupied    <= 1'b0;
    end else begin
      if (state == CLEAR) clr_row <= clr_row + 1'b1;
      if (state == ACCEPT && coord_valid) begin
        cap_x <= coord_x;
        cap_y <= coord_y;
      end
      if (finish && (state == CLEAR || state == WRITE || (state == ACCEPT && coord_valid)))
        finish_pending <= 1'b1;
      dup_flag <= (state == WRITE) && cap_is_set;
      oob_flag <= (state == WRITE) && !cap_in_range;
      if (state == WRITE && cap_in_range && !cap_is_set && map_full) overflow <= 1'b1;
      if (do_commit) point_count <= point_count + 1'b1;
      if (rd_en) rd_occupied <= rd_in_range && bitmap[rd_y[YW-1:0]][rd_x[XW-1:0]];
    end
  end

  // NOTE: the bitmap has no reset; the clear sweep after every reset zeroes it row by row.
  always_ff @(posedge clk) begin
    if (state == CLEAR)
      bitmap[clr_row] <= '0;
    else if (do_commit)
      bitmap[cap_y[YW-1:0]][cap_x[XW-1:0]] <= 1'b1;
  end

endmodule
